// File: rtl/moore_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_det_pkg : shared state encoding and match-counter constants for     |
// |                 the Moore run detector.                                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package moore_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_MATCH = 2'b10
  } state_t;

  localparam int                     MATCH_CNT_W   = 16;
  localparam logic [MATCH_CNT_W-1:0] MATCH_CNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/moore_det_next_state.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_det_next_state : combinational next-state / next-run-count logic   |
// |                        of the Moore run detector.                        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module moore_det_next_state
  import moore_det_pkg::*;
#(
  parameter int RUN_LEN    = 3,
  parameter int DETECT_VAL = 1,
  parameter int OVERLAP    = 1,
  parameter int CW         = 2
) (
  input  logic          i_w,
  input  logic          i_enable,
  input  state_t        i_state,
  input  logic [CW-1:0] i_run,
  output state_t        o_stateNext,
  output logic [CW-1:0] o_runNext
);

  localparam logic [CW-1:0] c_runMax   = CW'(RUN_LEN);
  localparam logic [CW-1:0] c_runOne   = CW'(1);
  localparam logic          c_detect   = 1'(DETECT_VAL);
  localparam state_t        c_firstHit = (RUN_LEN == 1) ? S_MATCH : S_COUNT;

  logic [CW-1:0] w_runInc;
  assign w_runInc = i_run + c_runOne;

  always_comb begin
    o_stateNext = i_state;
    o_runNext   = i_run;
    // Unreachable encodings recover to idle even while sampling is paused.
    if (i_state != S_IDLE && i_state != S_COUNT && i_state != S_MATCH) begin
      o_stateNext = S_IDLE;
      o_runNext   = '0;
    end else if (i_enable) begin
      if (i_w != c_detect) begin
        o_stateNext = S_IDLE;
        o_runNext   = '0;
      end else begin
        case (i_state)
          S_IDLE: begin
            o_stateNext = c_firstHit;
            o_runNext   = c_runOne;
          end
          S_COUNT: begin
            o_stateNext = (w_runInc == c_runMax) ? S_MATCH : S_COUNT;
            o_runNext   = w_runInc;
          end
          S_MATCH: begin
            if (OVERLAP != 0) begin
              o_stateNext = S_MATCH;
              o_runNext   = c_runMax;
            end else begin
              o_stateNext = c_firstHit;
              o_runNext   = c_runOne;
            end
          end
          default: begin
            o_stateNext = S_IDLE;
            o_runNext   = '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/moore_run_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_run_detector : parametrised Moore detector flagging RUN_LEN         |
// |   consecutive enabled samples of DETECT_VAL. Optional saturating match    |
// |   counter enabled by defining CONTROL_MATCH_COUNT_EN.                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module moore_run_detector
  import moore_det_pkg::*;
#(
  parameter int  RUN_LEN    = 3,
  parameter int  DETECT_VAL = 1,
  parameter int  OVERLAP    = 1,
  localparam int CW         = $clog2(RUN_LEN + 1)
) (
  input  logic          inputClk,
  input  logic          inputReset,
  input  logic          inputW,
  input  logic          inputEnable,
  output logic          outputZ,
  output logic [CW-1:0] outputRun
`ifdef CONTROL_MATCH_COUNT_EN
  ,
  output logic [MATCH_CNT_W-1:0] outputMatchCount
`endif
);

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_run;
  logic [CW-1:0] w_runNext;

  moore_det_next_state #(
    .RUN_LEN    (RUN_LEN),
    .DETECT_VAL (DETECT_VAL),
    .OVERLAP    (OVERLAP),
    .CW         (CW)
  ) u_nextState (
    .i_w         (inputW),
    .i_enable    (inputEnable),
    .i_state     (r_state),
    .i_run       (r_run),
    .o_stateNext (w_stateNext),
    .o_runNext   (w_runNext)
  );

  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      r_state <= S_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_run   <= w_runNext;
    end
  end

  // Z decodes only the state register, so W never reaches it combinationally.
  assign outputZ   = (r_state == S_MATCH);
  assign outputRun = r_run;

`ifdef CONTROL_MATCH_COUNT_EN
  // With single-sample runs and no overlap, each matching sample is a fresh match.
  localparam logic c_rematchInPlace = (OVERLAP == 0) && (RUN_LEN == 1);

  logic [MATCH_CNT_W-1:0] r_matchCount;
  logic                   w_matchEntry;

  assign w_matchEntry = inputEnable && (w_stateNext == S_MATCH) &&
                        ((r_state != S_MATCH) || c_rematchInPlace);

  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      r_matchCount <= '0;
    end else if (w_matchEntry && (r_matchCount != MATCH_CNT_MAX)) begin
      r_matchCount <= r_matchCount + 1'b1;
    end
  end

  assign outputMatchCount = r_matchCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_run_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_moore_run_detector : scoreboard bench over three detector configs.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_moore_run_detector;

  typedef struct {
    int z;
    int run;
    int mc;
  } exp_t;

  exp_t sbq[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: RUN_LEN=3, DETECT_VAL=1, OVERLAP=1
  logic rstA = 1'b0, wA = 1'b0, enA = 1'b0, zA;
  logic [1:0] runA;
  // B: RUN_LEN=3, DETECT_VAL=1, OVERLAP=0
  logic rstB = 1'b0, wB = 1'b0, enB = 1'b0, zB;
  logic [1:0] runB;
  // C: RUN_LEN=1, DETECT_VAL=0, OVERLAP=0
  logic rstC = 1'b0, wC = 1'b1, enC = 1'b0, zC;
  logic [0:0] runC;
`ifdef CONTROL_MATCH_COUNT_EN
  logic [15:0] mcA, mcB, mcC;
`endif

  moore_run_detector #(.RUN_LEN(3), .DETECT_VAL(1), .OVERLAP(1)) dutA (
    .inputClk(clk), .inputReset(rstA), .inputW(wA), .inputEnable(enA),
    .outputZ(zA), .outputRun(runA)
`ifdef CONTROL_MATCH_COUNT_EN
    , .outputMatchCount(mcA)
`endif
  );

  moore_run_detector #(.RUN_LEN(3), .DETECT_VAL(1), .OVERLAP(0)) dutB (
    .inputClk(clk), .inputReset(rstB), .inputW(wB), .inputEnable(enB),
    .outputZ(zB), .outputRun(runB)
`ifdef CONTROL_MATCH_COUNT_EN
    , .outputMatchCount(mcB)
`endif
  );

  moore_run_detector #(.RUN_LEN(1), .DETECT_VAL(0), .OVERLAP(0)) dutC (
    .inputClk(clk), .inputReset(rstC), .inputW(wC), .inputEnable(enC),
    .outputZ(zC), .outputRun(runC)
`ifdef CONTROL_MATCH_COUNT_EN
    , .outputMatchCount(mcC)
`endif
  );

  task automatic test_reset();
    exp_t e;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    enA = 1'b1; enB = 1'b0; enC = 1'b1;
    wA = 1'b1; wB = 1'b1; wC = 1'b0;
    sbq.push_back('{0, 0, 0});
    @(posedge clk); #1;
    e = sbq.pop_front();
    nCompared += 6;
    if (zA !== e.z[0])     begin nMismatched++; $display("FAIL reset zA: got %b want %b", zA, e.z[0]); end
    if (runA !== e.run[1:0]) begin nMismatched++; $display("FAIL reset runA: got %0d want %0d", runA, e.run); end
    if (zB !== e.z[0])     begin nMismatched++; $display("FAIL reset zB: got %b want %b", zB, e.z[0]); end
    if (runB !== e.run[1:0]) begin nMismatched++; $display("FAIL reset runB: got %0d want %0d", runB, e.run); end
    if (zC !== e.z[0])     begin nMismatched++; $display("FAIL reset zC: got %b want %b", zC, e.z[0]); end
    if (runC !== e.run[0:0]) begin nMismatched++; $display("FAIL reset runC: got %0d want %0d", runC, e.run); end
`ifdef CONTROL_MATCH_COUNT_EN
    nCompared += 3;
    if (mcA !== e.mc[15:0]) begin nMismatched++; $display("FAIL reset mcA: got %0d want %0d", mcA, e.mc); end
    if (mcB !== e.mc[15:0]) begin nMismatched++; $display("FAIL reset mcB: got %0d want %0d", mcB, e.mc); end
    if (mcC !== e.mc[15:0]) begin nMismatched++; $display("FAIL reset mcC: got %0d want %0d", mcC, e.mc); end
`endif
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    enA = 1'b0; enB = 1'b0; enC = 1'b0;
  endtask

  task automatic test_overlap();
    int wv[5] = '{1, 1, 1, 1, 0};
    int ez[5] = '{0, 0, 1, 1, 0};
    int er[5] = '{1, 2, 3, 3, 0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      enA = 1'b1; wA = wv[i][0];
      sbq.push_back('{ez[i], er[i], 1});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zA !== e.z[0]) begin nMismatched++; $display("FAIL overlap z step %0d: got %b want %b", i, zA, e.z[0]); end
      if (runA !== e.run[1:0]) begin nMismatched++; $display("FAIL overlap run step %0d: got %0d want %0d", i, runA, e.run); end
`ifdef CONTROL_MATCH_COUNT_EN
      if (i == 4) begin
        nCompared++;
        if (mcA !== e.mc[15:0]) begin nMismatched++; $display("FAIL overlap count: got %0d want %0d", mcA, e.mc); end
      end
`endif
    end
  endtask

  task automatic test_hold();
    int en[7] = '{1, 1, 0, 0, 0, 0, 1};
    int wv[7] = '{1, 1, 0, 0, 0, 0, 1};
    int ez[7] = '{0, 0, 0, 0, 0, 0, 1};
    int er[7] = '{1, 2, 2, 2, 2, 2, 3};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      enA = en[i][0]; wA = wv[i][0];
      sbq.push_back('{ez[i], er[i], 0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zA !== e.z[0]) begin nMismatched++; $display("FAIL hold z step %0d: got %b want %b", i, zA, e.z[0]); end
      if (runA !== e.run[1:0]) begin nMismatched++; $display("FAIL hold run step %0d: got %0d want %0d", i, runA, e.run); end
    end
  endtask

  task automatic test_reset_mid_run();
    int rs[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    int en[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int wv[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    int ez[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int er[8] = '{0, 1, 2, 3, 0, 1, 2, 0};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      rstA = rs[i][0]; enA = en[i][0]; wA = wv[i][0];
      sbq.push_back('{ez[i], er[i], 0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zA !== e.z[0]) begin nMismatched++; $display("FAIL midreset z step %0d: got %b want %b", i, zA, e.z[0]); end
      if (runA !== e.run[1:0]) begin nMismatched++; $display("FAIL midreset run step %0d: got %0d want %0d", i, runA, e.run); end
    end
    rstA = 1'b0; enA = 1'b0;
  endtask

  task automatic test_no_overlap();
    int ez[7] = '{0, 0, 1, 0, 0, 1, 0};
    int er[7] = '{1, 2, 3, 1, 2, 3, 1};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      enB = 1'b1; wB = 1'b1;
      sbq.push_back('{ez[i], er[i], 2});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zB !== e.z[0]) begin nMismatched++; $display("FAIL nooverlap z step %0d: got %b want %b", i, zB, e.z[0]); end
      if (runB !== e.run[1:0]) begin nMismatched++; $display("FAIL nooverlap run step %0d: got %0d want %0d", i, runB, e.run); end
`ifdef CONTROL_MATCH_COUNT_EN
      if (i == 6) begin
        nCompared++;
        if (mcB !== e.mc[15:0]) begin nMismatched++; $display("FAIL nooverlap count: got %0d want %0d", mcB, e.mc); end
      end
`endif
    end
  endtask

  task automatic test_random_b();
    int   mrun;
    logic w, en;
    exp_t e;
    enB = 1'b1; wB = 1'b0;
    sbq.push_back('{0, 0, 0});
    mrun = 0;
    @(posedge clk); #1;
    e = sbq.pop_front();
    nCompared++;
    if (runB !== e.run[1:0]) begin nMismatched++; $display("FAIL random clear run: got %0d want %0d", runB, e.run); end
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 4) != 0);
      enB = en; wB = w;
      if (en) begin
        if (!w)             mrun = 0;
        else if (mrun == 3) mrun = 1;
        else                mrun = mrun + 1;
      end
      sbq.push_back('{(mrun == 3) ? 1 : 0, mrun, 0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zB !== e.z[0]) begin nMismatched++; $display("FAIL random z step %0d: got %b want %b", i, zB, e.z[0]); end
      if (runB !== e.run[1:0]) begin nMismatched++; $display("FAIL random run step %0d: got %0d want %0d", i, runB, e.run); end
    end
    enB = 1'b0;
  endtask

  task automatic test_run_len_one();
    int wv[4] = '{0, 0, 1, 0};
    int ez[4] = '{1, 1, 0, 1};
    int er[4] = '{1, 1, 0, 1};
    int em[4] = '{1, 2, 2, 3};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      enC = 1'b1; wC = wv[i][0];
      sbq.push_back('{ez[i], er[i], em[i]});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared += 2;
      if (zC !== e.z[0]) begin nMismatched++; $display("FAIL runlen1 z step %0d: got %b want %b", i, zC, e.z[0]); end
      if (runC !== e.run[0:0]) begin nMismatched++; $display("FAIL runlen1 run step %0d: got %0d want %0d", i, runC, e.run); end
`ifdef CONTROL_MATCH_COUNT_EN
      nCompared++;
      if (mcC !== e.mc[15:0]) begin nMismatched++; $display("FAIL runlen1 count step %0d: got %0d want %0d", i, mcC, e.mc); end
`endif
    end
    enC = 1'b0;
  endtask

`ifdef CONTROL_MATCH_COUNT_EN
  task automatic test_saturation();
    exp_t e;
    // Count stands at 3 here; bring it to 16'hFFFE with matching samples.
    enC = 1'b1; wC = 1'b0;
    repeat (65531) @(posedge clk);
    #1;
    sbq.push_back('{1, 1, 32'hFFFE});
    e = sbq.pop_front();
    nCompared++;
    if (mcC !== e.mc[15:0]) begin nMismatched++; $display("FAIL saturate preload: got %h want %h", mcC, e.mc[15:0]); end
    for (int i = 0; i < 3; i++) begin
      wC = 1'b0;
      sbq.push_back('{1, 1, 32'hFFFF});
      @(posedge clk); #1;
      e = sbq.pop_front();
      nCompared++;
      if (mcC !== e.mc[15:0]) begin nMismatched++; $display("FAIL saturate step %0d: got %h want %h", i, mcC, e.mc[15:0]); end
    end
    enC = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_overlap();
    test_hold();
    test_reset_mid_run();
    test_no_overlap();
    test_random_b();
    test_run_len_one();
`ifdef CONTROL_MATCH_COUNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
